// File: rtl/tribus_if.sv
// tribus_if: bus-side signals of the tri-state bus arbiter.
//   req      : per-requester level-held request (from requesters)
//   grant    : one-hot grant, the requester prepares its data
//   oe       : one-hot tri-state output enable for requester drivers
//   park_en  : enable for the park/pull driver that holds the idle value
//   busy     : bus allocated (arbitration, ownership or turnaround)
//   owner_id : index of the current or most recent owner
//   timeout  : one-cycle pulse after a forced release
// The arbiter uses the master modport; requesters use the slave modport.
interface tribus_if #(
   parameter int N_REQ = 4
);
   localparam int IDW = $clog2(N_REQ);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] oe;
   logic             park_en;
   logic             busy;
   logic [IDW-1:0]   owner_id;
   logic             timeout;

   modport master (input req, output grant, oe, park_en, busy, owner_id, timeout);
   modport slave  (output req, input grant, oe, park_en, busy, owner_id, timeout);
endinterface

// File: rtl/tribus_arbiter.sv
// tribus_arbiter: round-robin arbiter and sequencer for a shared tri-state bus.
// At most one requester drives the bus at a time. Every tenure is framed by a
// one-cycle grant-only (ARB) cycle before oe and TURN undriven cycles after it,
// so two drivers never overlap. The park driver holds the bus while idle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tribus_if master modport (req in; grant/oe/park_en/busy/
//           owner_id/timeout out, all registered)
module tribus_arbiter #(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 8,
   parameter int TURN     = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   tribus_if.master bus
);
   localparam int IDW = $clog2(N_REQ);
   localparam int HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam int TW  = (TURN > 1) ? $clog2(TURN) : 1;
   localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [TW-1:0]  TURN_LAST = TW'(TURN - 1);
   localparam logic [IDW-1:0] LAST_IDX  = IDW'(N_REQ - 1);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_OWN, S_TURN} state_t;

   state_t           state;
   logic [N_REQ-1:0] grant_q, oe_q;
   logic             park_q, busy_q, timeout_q;
   logic [IDW-1:0]   owner_q, rr_ptr, win, nxt_ptr;
   logic [HW-1:0]    hold_cnt;
   logic [TW-1:0]    turn_cnt;

   // First set request at or after the round-robin pointer, wrapping.
   function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IDW-1:0]   p);
      logic [IDW-1:0] w;
      logic           found;
      int             idx;
      w     = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(p) + i) % N_REQ;
         if (!found && r[idx[IDW-1:0]]) begin
            w     = idx[IDW-1:0];
            found = 1'b1;
         end
      end
      return w;
   endfunction

   always_comb begin
      win     = rr_pick(bus.req, rr_ptr);
      nxt_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         grant_q   <= '0;
         oe_q      <= '0;
         park_q    <= 1'b1;
         busy_q    <= 1'b0;
         owner_q   <= '0;
         timeout_q <= 1'b0;
         rr_ptr    <= '0;
         hold_cnt  <= '0;
         turn_cnt  <= '0;
      end else begin
         timeout_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (|bus.req) begin
                  state   <= S_ARB;
                  owner_q <= win;
                  grant_q <= N_REQ'(1) << win;
                  park_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            // Park released, grant up, nobody driving yet.
            S_ARB: begin
               if (bus.req[owner_q]) begin
                  state    <= S_OWN;
                  hold_cnt <= '0;
                  oe_q     <= grant_q;
               end else begin
                  state    <= S_TURN;
                  grant_q  <= '0;
                  rr_ptr   <= nxt_ptr;
                  turn_cnt <= '0;
               end
            end
            S_OWN: begin
               if (!bus.req[owner_q] || hold_cnt == HOLD_LAST) begin
                  state     <= S_TURN;
                  grant_q   <= '0;
                  oe_q      <= '0;
                  rr_ptr    <= nxt_ptr;
                  turn_cnt  <= '0;
                  // Still requesting here means the hold limit forced release.
                  timeout_q <= bus.req[owner_q];
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            S_TURN: begin
               if (turn_cnt == TURN_LAST) begin
                  if (|bus.req) begin
                     // Back-to-back tenure: park stays off.
                     state   <= S_ARB;
                     owner_q <= win;
                     grant_q <= N_REQ'(1) << win;
                  end else begin
                     state  <= S_IDLE;
                     park_q <= 1'b1;
                     busy_q <= 1'b0;
                  end
               end else begin
                  turn_cnt <= turn_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.grant    = grant_q;
   assign bus.oe       = oe_q;
   assign bus.park_en  = park_q;
   assign bus.busy     = busy_q;
   assign bus.owner_id = owner_q;
   assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_tribus_arbiter.sv
// Directed bench for tribus_arbiter: instance A (MAX_HOLD=8, TURN=1) and
// instance B (MAX_HOLD=8, TURN=3), with bus invariants checked every cycle.
module tb_tribus_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   tribus_if #(.N_REQ(4)) ba ();
   tribus_if #(.N_REQ(4)) bb ();

   tribus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .TURN(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
   tribus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .TURN(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [3:0] g, input logic [3:0] o,
                        input logic pk, input logic bz);
      chk({tag, ".grant"}, 32'(ba.grant), 32'(g));
      chk({tag, ".oe"}, 32'(ba.oe), 32'(o));
      chk({tag, ".park"}, 32'(ba.park_en), 32'(pk));
      chk({tag, ".busy"}, 32'(ba.busy), 32'(bz));
   endtask

   task automatic chk_b(input string tag, input logic [3:0] g, input logic [3:0] o,
                        input logic pk, input logic bz);
      chk({tag, ".grant"}, 32'(bb.grant), 32'(g));
      chk({tag, ".oe"}, 32'(bb.oe), 32'(o));
      chk({tag, ".park"}, 32'(bb.park_en), 32'(pk));
      chk({tag, ".busy"}, 32'(bb.busy), 32'(bz));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bus-safety invariants on both instances.
   logic [3:0] prev_a = '0, prev_b = '0;
   always @(negedge clk) begin
      chk("inv_a_onehot", 32'($countones(ba.oe) <= 1), 32'd1);
      chk("inv_a_subset", 32'(ba.oe & ~ba.grant), 32'd0);
      chk("inv_a_park", 32'(ba.park_en && (ba.oe != 0)), 32'd0);
      chk("inv_a_switch", 32'((prev_a != 0) && (ba.oe != 0) && (ba.oe != prev_a)), 32'd0);
      chk("inv_b_onehot", 32'($countones(bb.oe) <= 1), 32'd1);
      chk("inv_b_subset", 32'(bb.oe & ~bb.grant), 32'd0);
      chk("inv_b_park", 32'(bb.park_en && (bb.oe != 0)), 32'd0);
      chk("inv_b_switch", 32'((prev_b != 0) && (bb.oe != 0) && (bb.oe != prev_b)), 32'd0);
      prev_a = ba.oe;
      prev_b = bb.oe;
   end

   initial begin
      int         ks[5];
      logic [3:0] oh;
      ks = '{0, 1, 2, 3, 0};
      ba.req = '0;
      bb.req = '0;
      rst_n  = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk_a("rst", 4'b0000, 4'b0000, 1'b1, 1'b0);
      chk("rst.owner", 32'(ba.owner_id), 32'd0);
      chk("rst.timeout", 32'(ba.timeout), 32'd0);
      chk_b("rst_b", 4'b0000, 4'b0000, 1'b1, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;

      // Single requester 2, three oe cycles, voluntary release.
      ba.req = 4'b0100;
      tick(); chk_a("t2_arb", 4'b0100, 4'b0000, 1'b0, 1'b1);
      chk("t2_arb.owner", 32'(ba.owner_id), 32'd2);
      tick(); chk_a("t2_own1", 4'b0100, 4'b0100, 1'b0, 1'b1);
      tick(); chk_a("t2_own2", 4'b0100, 4'b0100, 1'b0, 1'b1);
      tick(); chk_a("t2_own3", 4'b0100, 4'b0100, 1'b0, 1'b1);
      ba.req = 4'b0000;
      tick(); chk_a("t2_turn", 4'b0000, 4'b0000, 1'b0, 1'b1);
      chk("t2_turn.timeout", 32'(ba.timeout), 32'd0);
      tick(); chk_a("t2_idle", 4'b0000, 4'b0000, 1'b1, 1'b0);
      chk("t2_idle.owner", 32'(ba.owner_id), 32'd2);

      // Reset asserted mid-tenure clears outputs without a clock edge.
      ba.req = 4'b0001;
      tick(); chk("t1_arb.owner", 32'(ba.owner_id), 32'd0);
      tick(); chk_a("t1_own", 4'b0001, 4'b0001, 1'b0, 1'b1);
      tick(); chk_a("t1_own2", 4'b0001, 4'b0001, 1'b0, 1'b1);
      rst_n = 1'b0;
      #2;
      chk_a("t1_async", 4'b0000, 4'b0000, 1'b1, 1'b0);
      chk("t1_async.owner", 32'(ba.owner_id), 32'd0);
      ba.req = 4'b1111;
      tick();
      rst_n = 1'b1;

      // All requesting: rotation 0,1,2,3,0 with forced release each time
      // (first winner 0 also shows the pointer was cleared by reset).
      for (int t = 0; t < 5; t++) begin
         oh = 4'b0001 << ks[t];
         tick(); chk_a($sformatf("t3_arb%0d", t), oh, 4'b0000, 1'b0, 1'b1);
         chk($sformatf("t3_arb%0d.owner", t), 32'(ba.owner_id), 32'(ks[t]));
         chk($sformatf("t3_arb%0d.timeout", t), 32'(ba.timeout), 32'd0);
         for (int c = 0; c < 8; c++) begin
            tick(); chk_a($sformatf("t3_own%0d_%0d", t, c), oh, oh, 1'b0, 1'b1);
         end
         tick(); chk_a($sformatf("t3_turn%0d", t), 4'b0000, 4'b0000, 1'b0, 1'b1);
         chk($sformatf("t3_turn%0d.timeout", t), 32'(ba.timeout), 32'd1);
         if (t == 4) ba.req = 4'b0000;
      end
      tick(); chk_a("t3_idle", 4'b0000, 4'b0000, 1'b1, 1'b0);

      // Abort during ARB: requester 1 drops, pointer moves to 2.
      ba.req = 4'b0010;
      tick(); chk_a("t4_arb", 4'b0010, 4'b0000, 1'b0, 1'b1);
      chk("t4_arb.owner", 32'(ba.owner_id), 32'd1);
      ba.req = 4'b0000;
      tick(); chk_a("t4_turn", 4'b0000, 4'b0000, 1'b0, 1'b1);
      chk("t4_turn.timeout", 32'(ba.timeout), 32'd0);
      ba.req = 4'b0110;
      tick(); chk_a("t4_arb2", 4'b0100, 4'b0000, 1'b0, 1'b1);
      chk("t4_arb2.owner", 32'(ba.owner_id), 32'd2);
      ba.req = 4'b0000;
      tick(); chk_a("t4_turn2", 4'b0000, 4'b0000, 1'b0, 1'b1);
      tick(); chk_a("t4_idle", 4'b0000, 4'b0000, 1'b1, 1'b0);

      // Owner 3 releases as 0 arrives: straight to ARB without parking.
      ba.req = 4'b1000;
      tick(); chk("t5_arb.owner", 32'(ba.owner_id), 32'd3);
      tick(); chk_a("t5_own", 4'b1000, 4'b1000, 1'b0, 1'b1);
      ba.req = 4'b0001;
      tick(); chk_a("t5_turn", 4'b0000, 4'b0000, 1'b0, 1'b1);
      chk("t5_turn.timeout", 32'(ba.timeout), 32'd0);
      tick(); chk_a("t5_arb2", 4'b0001, 4'b0000, 1'b0, 1'b1);
      chk("t5_arb2.owner", 32'(ba.owner_id), 32'd0);
      ba.req = 4'b0000;
      tick(); tick(); chk_a("t5_idle", 4'b0000, 4'b0000, 1'b1, 1'b0);

      // TURN=3 instance: lone requester 1 held, regranted after 3 idle cycles.
      bb.req = 4'b0010;
      for (int t = 0; t < 2; t++) begin
         tick(); chk_b($sformatf("t6_arb%0d", t), 4'b0010, 4'b0000, 1'b0, 1'b1);
         chk($sformatf("t6_arb%0d.owner", t), 32'(bb.owner_id), 32'd1);
         for (int c = 0; c < 8; c++) begin
            tick(); chk_b($sformatf("t6_own%0d_%0d", t, c), 4'b0010, 4'b0010, 1'b0, 1'b1);
         end
         tick(); chk_b($sformatf("t6_turn%0d_0", t), 4'b0000, 4'b0000, 1'b0, 1'b1);
         chk($sformatf("t6_turn%0d_0.timeout", t), 32'(bb.timeout), 32'd1);
         tick(); chk_b($sformatf("t6_turn%0d_1", t), 4'b0000, 4'b0000, 1'b0, 1'b1);
         chk($sformatf("t6_turn%0d_1.timeout", t), 32'(bb.timeout), 32'd0);
         tick(); chk_b($sformatf("t6_turn%0d_2", t), 4'b0000, 4'b0000, 1'b0, 1'b1);
         chk($sformatf("t6_turn%0d_2.timeout", t), 32'(bb.timeout), 32'd0);
      end
      tick(); chk_b("t6_arb2", 4'b0010, 4'b0000, 1'b0, 1'b1);
      bb.req = 4'b0000;
      tick(); chk_b("t6_abort", 4'b0000, 4'b0000, 1'b0, 1'b1);
      tick(); tick(); chk_b("t6_turn_last", 4'b0000, 4'b0000, 1'b0, 1'b1);
      tick(); chk_b("t6_idle", 4'b0000, 4'b0000, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
